// File: rtl/div_16bit_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and
// the width of the iteration counter.
package div_16bit_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sub_17bit.sv
// 17-bit trial subtractor: Diff = A - B formed as A + ~B + 1 with a
// parallel-prefix carry-lookahead network; Borrow is the inverted carry out.
module sub_17bit (
   input  logic [16:0] A,
   input  logic [16:0] B,
   output logic [16:0] Diff,
   output logic        Borrow
);

   localparam int unsigned N = 17;

   logic [N-1:0] bn, g, p, gg, pp, gs, ps, c;

   always_comb begin
      bn = ~B;
      p  = A ^ bn;
      g  = A & bn;
      // The +1 is folded in as a carry-in of 1 to bit 0.
      gg    = g;
      gg[0] = g[0] | p[0];
      pp    = p;
      gs    = '0;
      ps    = '0;
      for (int unsigned d = 1; d < N; d = d * 2) begin
         gs = gg;
         ps = pp;
         for (int unsigned i = d; i < N; i++) begin
            gg[i] = gs[i] | (ps[i] & gs[i-d]);
            pp[i] = ps[i] & ps[i-d];
         end
      end
      c      = {gg[N-2:0], 1'b1};
      Diff   = p ^ c;
      Borrow = ~gg[N-1];
   end

endmodule

// File: rtl/div_16bit.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, with a
// short-cut completion for a zero divisor.
module div_16bit
   import div_16bit_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             Error
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             err_q, err_d;

   logic [WIDTH:0]   shifted, diff;
   logic             borrow;
   logic [WIDTH-1:0] part_nxt;
   logic [WIDTH-1:0] quot_nxt;
   logic             unused_diff_msb;

   // dvd_q doubles as the quotient accumulator: dividend bits leave at the
   // top while quotient bits enter at the bottom.
   assign shifted         = {part_q, dvd_q[WIDTH-1]};
   assign part_nxt        = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quot_nxt        = {dvd_q[WIDTH-2:0], ~borrow};
   assign unused_diff_msb = diff[WIDTH];

   sub_17bit u_sub (
      .A      (shifted),
      .B      ({1'b0, dvs_q}),
      .Diff   (diff),
      .Borrow (borrow)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         part_q  <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         part_q  <= part_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      part_d  = part_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               part_d  = '0;
               cnt_d   = '0;
               state_d = CALC;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (dvs_q == '0) begin
               quot_d  = '1;
               rem_d   = dvd_q;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               part_d = part_nxt;
               dvd_d  = quot_nxt;
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  quot_d  = quot_nxt;
                  rem_d   = part_nxt;
                  err_d   = 1'b0;
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q == CALC);
   assign done      = (state_q == DONE);
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign Error     = err_q;

endmodule
